pwm_demod: RTL and testbench
============================

// Module: pwm_demod
// PURPOSE
//  Receive end of the 11-bit audio PWM link: recovers each duty-cycle sample from a PWM pin.
//  Counts the high cycles in each PWM period, measured rising edge to rising edge.
//  Emits one sample per period with a 1-cycle valid strobe, plus lock and period-error flags.
//  Used for loopback test of the tone/arp path and as the front end of the audio input.
// PARAMETERS
//  SAMPLE_W  11    sample width; full scale = 2**SAMPLE_W-1
//  PERIOD    2048  nominal PWM period in clocks
//  TOL       4     allowed |measured period - PERIOD| before period_err
//  TIMEOUT   4096  clocks without a rising edge before the input is declared stuck
// PORTS
//  CLK100MHZ     in   1         system clock
//  CPU_RESETN    in   1         asynchronous, active-low reset
//  PWM_in        in   1         PWM line, asynchronous to CLK100MHZ
//  sample        out  SAMPLE_W  last recovered sample
//  sample_valid  out  1         1-cycle strobe: sample updated
//  locked        out  1         tracking edges and the last period was within TOL
//  period_err    out  1         last completed period was outside PERIOD±TOL (sticky until next period)
// BEHAVIOUR
//  - Reset (async, CPU_RESETN=0): sample=0, sample_valid=0, locked=0, period_err=0, state=IDLE.
//    All counters, synchronizer flops and history are cleared; a mid-period reset discards the partial period.
//  - PWM_in passes through a 2-FF synchronizer (in_s). rise = in_s & ~in_s_d.
//  - per_cnt counts clocks; hi_cnt counts clocks with in_s=1. Both saturate at TIMEOUT.
//    On a rise cycle both load 1; every other cycle per_cnt+1 and hi_cnt+in_s.
//  - FSM states: IDLE, TRACK, STUCK.
//    IDLE: rise -> TRACK, no sample emitted (partial period); per_cnt==TIMEOUT -> STUCK.
//    TRACK: rise -> emit sample = min(hi_cnt, 2**SAMPLE_W-1).
//      Same edge updates period_err = (|per_cnt-PERIOD| > TOL) and locked = ~that.
//      per_cnt==TIMEOUT -> STUCK, locked=0.
//    STUCK: every PERIOD clocks emit sample = in_s ? full scale : 0, keeping the output rate.
//      rise -> TRACK, no sample for that edge.
//  - Entering STUCK emits a level sample on the same cycle as the transition.
//  - Emit means: sample and sample_valid are registered and appear the cycle after the rise/timeout cycle.
//  - sample_valid is never high on two consecutive cycles.
//  - Latency: PWM_in rising edge to sample_valid = 4 clocks (2 sync + edge + output register).
//  - A duty of N high clocks in a PERIOD-clock period yields sample=N (N=1..2047).
//    N=0 (line never rises) is delivered through STUCK as 0.
//  - A rise and a timeout on the same cycle: the rise wins.
// CONFIGURATION
//  PWM_DEMOD_AVG_EN defined:
//   - sample = (sum of last 4 raw samples) >> 2, truncated.
//   - Sum register is SAMPLE_W+2 bits.
//   - Adds 1 clock of latency (5 clocks total).
//   - On each IDLE/STUCK->TRACK entry, all 4 history entries preload with the first raw TRACK sample.
//   - STUCK samples bypass the average.
//  PWM_DEMOD_AVG_EN undefined: sample = raw measured value, 4-clock latency.
// STRUCTURE
//  - Package pwm_pkg: SAMPLE_W/PERIOD defaults shared with pwm_module, demod_state_t enum {IDLE,TRACK,STUCK}.
//  - Package pwm_pkg: full-scale constant.
//  - Sub-module pwm_sync_edge: 2-FF synchronizer + rise detect; outputs in_s, rise. Reset clears both to 0.
//  - Counters, FSM, error logic and the optional averager live in pwm_demod.
// TESTING
//  1. Reset with PWM_in=0, hold 3000 clks: no sample_valid before clk 4096.
//     Then sample=0, valid, locked=0; repeats every 2048 clks.
//  2. Drive PERIOD=2048, duty 746 for 5 periods: first edge gives no sample; next 4 give sample=746.
//     sample_valid 4 clks after each rising edge; locked=1, period_err=0.
//  3. Step duty 100 -> 2047 -> 1: samples 100, 2047, 1 in consecutive periods, no missed strobe.
//  4. Period 2060 (|Δ|=12>4), duty 500: sample=500, period_err=1, locked=0.
//     Return to 2048: period_err=0, locked=1 after one period.
//  5. Hold PWM_in=1 after lock: STUCK after 4096 clks, sample=2047 each 2048 clks.
//     Restore PWM: first edge gives no sample, next edge gives the correct value.
//  6. Assert CPU_RESETN=0 mid-period for 1 clk: all outputs 0 immediately (async).
//     First post-reset edge gives no sample. Repeat scenario 2 with PWM_DEMOD_AVG_EN: samples 746, latency 5.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the audio PWM link (transmit and receive ends) and the demodulator state type.
package pwm_pkg;

    localparam int DEF_SAMPLE_W = 11;
    localparam int DEF_PERIOD   = 2048;
    localparam int DEF_TOL      = 4;
    localparam int DEF_TIMEOUT  = 4096;

    function automatic int full_scale(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int FULL_SCALE = (1 << DEF_SAMPLE_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        STUCK = 2'd2
    } demod_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Brings the asynchronous PWM line into the clock domain and flags its rising edge.
// in_s_o is delayed to line up with rise_o, so in_s_o is always 1 on a rise cycle.
module pwm_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic in_s_o,
    output logic rise_o
);

    logic [2:0] sync_q;
    logic       rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign in_s_o = sync_q[2];
    assign rise_o = rise_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM receive demodulator: one duty sample per rising-edge-to-rising-edge period, plus lock/error flags.
// Define PWM_DEMOD_AVG_EN for a 4-sample moving average on tracked samples (one extra clock of latency).
module pwm_demod
    import pwm_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int PERIOD   = DEF_PERIOD,
    parameter int TOL      = DEF_TOL,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic                PWM_in,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                locked,
    output logic                period_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]    PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]    TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]    FULL_C    = CNT_W'(full_scale(SAMPLE_W));
    localparam logic [STK_W-1:0]    PERIOD_S  = STK_W'(PERIOD);
    localparam logic [SAMPLE_W-1:0] FULL      = SAMPLE_W'(full_scale(SAMPLE_W));

    logic in_s, rise;

    pwm_sync_edge u_sync (
        .clk_i  (CLK100MHZ),
        .rst_ni (CPU_RESETN),
        .d_i    (PWM_in),
        .in_s_o (in_s),
        .rise_o (rise)
    );

    demod_state_t        state_q, state_d;
    logic [CNT_W-1:0]    per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d, dev;
    logic [STK_W-1:0]    stk_cnt_q, stk_cnt_d;
    logic                first_q, first_d, locked_q, locked_d, err_q, err_d;
    logic                timeout, bad;
    logic                emit_d;
    logic [SAMPLE_W-1:0] emit_val_d, hi_clamped, level;

    assign timeout    = (per_cnt_q == TIMEOUT_C);
    assign dev        = (per_cnt_q >= PERIOD_C) ? per_cnt_q - PERIOD_C : PERIOD_C - per_cnt_q;
    assign bad        = (dev > TOL_C);
    assign hi_clamped = (hi_cnt_q > FULL_C) ? FULL : hi_cnt_q[SAMPLE_W-1:0];
    assign level      = in_s ? FULL : '0;

    // Both counters include the rise cycle itself and saturate at the stuck threshold.
    always_comb begin
        if (rise) begin
            per_cnt_d = CNT_W'(1);
            hi_cnt_d  = CNT_W'(1);
        end else begin
            per_cnt_d = timeout ? per_cnt_q : per_cnt_q + CNT_W'(1);
            hi_cnt_d  = (hi_cnt_q == TIMEOUT_C || !in_s) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        stk_cnt_d  = stk_cnt_q;
        first_d    = first_q;
        locked_d   = locked_q;
        err_d      = err_q;
        emit_d     = 1'b0;
        emit_val_d = '0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = TRACK;
                    first_d = 1'b1;
                end else if (timeout) begin
                    state_d    = STUCK;
                    stk_cnt_d  = STK_W'(1);
                    emit_d     = 1'b1;
                    emit_val_d = level;
                end
            end
            TRACK: begin
                if (rise) begin
                    emit_d     = 1'b1;
                    emit_val_d = hi_clamped;
                    err_d      = bad;
                    locked_d   = ~bad;
                    first_d    = 1'b0;
                end else if (timeout) begin
                    state_d    = STUCK;
                    locked_d   = 1'b0;
                    stk_cnt_d  = STK_W'(1);
                    emit_d     = 1'b1;
                    emit_val_d = level;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d = TRACK;
                    first_d = 1'b1;
                end else if (stk_cnt_q == PERIOD_S) begin
                    stk_cnt_d  = STK_W'(1);
                    emit_d     = 1'b1;
                    emit_val_d = level;
                end else begin
                    stk_cnt_d = stk_cnt_q + STK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            stk_cnt_q <= '0;
            first_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            stk_cnt_q <= stk_cnt_d;
            first_q   <= first_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    logic [SAMPLE_W-1:0] sample_q;
    logic                valid_q;

`ifdef PWM_DEMOD_AVG_EN
    localparam int SUM_W = SAMPLE_W + 2;
    logic                raw_vld_q, raw_first_q, raw_stuck_q, lock_out_q, err_out_q, hist_load;
    logic [SAMPLE_W-1:0] raw_q;
    logic [SAMPLE_W-1:0] hist_q [4];
    logic [SUM_W-1:0]    sum_q, sum_d;

    assign hist_load = raw_vld_q & ~raw_stuck_q;

    // The first tracked sample after (re)acquiring fills the whole window so the average starts settled.
    always_comb begin
        sum_d = sum_q;
        if (hist_load) begin
            sum_d = raw_first_q ? {raw_q, 2'b00}
                                : sum_q - SUM_W'(hist_q[3]) + SUM_W'(raw_q);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            raw_vld_q   <= 1'b0;
            raw_q       <= '0;
            raw_first_q <= 1'b0;
            raw_stuck_q <= 1'b0;
            lock_out_q  <= 1'b0;
            err_out_q   <= 1'b0;
            sum_q       <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
        end else begin
            raw_vld_q   <= emit_d;
            raw_first_q <= first_q;
            raw_stuck_q <= !(state_q == TRACK && rise);
            lock_out_q  <= locked_q;
            err_out_q   <= err_q;
            sum_q       <= sum_d;
            valid_q     <= raw_vld_q;
            if (emit_d) raw_q <= emit_val_d;
            if (raw_vld_q) sample_q <= raw_stuck_q ? raw_q : sum_d[SUM_W-1:2];
            if (hist_load) begin
                hist_q[0] <= raw_q;
                for (int i = 1; i < 4; i++) hist_q[i] <= raw_first_q ? raw_q : hist_q[i-1];
            end
        end
    end

    assign locked     = lock_out_q;
    assign period_err = err_out_q;
`else
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= emit_d;
            if (emit_d) sample_q <= emit_val_d;
        end
    end

    assign locked     = locked_q;
    assign period_err = err_q;
`endif

    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: directed and randomized PWM periods compared against a period-level reference model.
module tb_pwm_demod;

    localparam int PER = 2048;
    localparam int TOL = 4;
    localparam int TMO = 4096;
    localparam int FS  = 2047;
`ifdef PWM_DEMOD_AVG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic        CLK100MHZ  = 1'b0;
    logic        CPU_RESETN = 1'b0;
    logic        PWM_in     = 1'b0;
    logic [10:0] sample;
    logic        sample_valid, locked, period_err;

    pwm_demod dut (
        .CLK100MHZ    (CLK100MHZ),
        .CPU_RESETN   (CPU_RESETN),
        .PWM_in       (PWM_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .locked       (locked),
        .period_err   (period_err)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int cyc = 0;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
        bit lk;
        bit er;
    } ev_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    int   doubles = 0;
    logic prev_v  = 1'b0;

    always @(negedge CLK100MHZ) begin
        if (sample_valid) obs_q.push_back('{cyc: cyc, val: int'(sample), lk: locked, er: period_err});
        if (sample_valid && prev_v) doubles++;
        prev_v = sample_valid;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input int got, input int want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    endtask

    // Reference model: works on whole periods (rise times and high lengths), not on RTL state.
    bit tracking  = 1'b0;
    bit first_rep = 1'b0;
    bit last_err  = 1'b0;
    int last_rise = 0;
    int last_hi   = 0;
    int hist[$];

    task automatic push_exp(input int at, input int raw, input bit lk, input bit er, input bit stuck);
        int v;
        v = raw;
`ifdef PWM_DEMOD_AVG_EN
        if (!stuck) begin
            if (first_rep) begin
                hist = {raw, raw, raw, raw};
            end else begin
                hist.push_front(raw);
                void'(hist.pop_back());
            end
            v = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
        end
`endif
        if (!stuck) first_rep = 1'b0;
        exp_q.push_back('{cyc: at, val: v, lk: lk, er: er});
    endtask

    task automatic model_rise();
        int per;
        bit bad;
        per = cyc - last_rise;
        bad = (per > PER + TOL) || (per < PER - TOL);
        if (tracking) begin
            last_err = bad;
            push_exp(cyc + LAT, (last_hi > FS) ? FS : last_hi, !bad, bad, 1'b0);
        end else begin
            first_rep = 1'b1;
        end
        tracking  = 1'b1;
        last_rise = cyc;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic drive_period(input int per, input int duty);
        PWM_in = 1'b1;
        model_rise();
        last_hi = duty;
        step(duty);
        PWM_in = 1'b0;
        step(per - duty);
    endtask

    task automatic compare_all(input string tag);
        ev_t o, e;
        step(LAT + 4);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            $display("%s: cyc=%0d sample=%0d locked=%0b err=%0b (want cyc=%0d sample=%0d locked=%0b err=%0b)",
                     tag, o.cyc, o.val, o.lk, o.er, e.cyc, e.val, e.lk, e.er);
            check({tag, "_cyc"}, o.cyc, e.cyc);
            check({tag, "_sample"}, o.val, e.val);
            check({tag, "_locked"}, int'(o.lk), int'(e.lk));
            check({tag, "_err"}, int'(o.er), int'(e.er));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    int pers[$];
    int duts[$];
    int r0, d0, hold_rise, p;

    initial begin
        // Reset with the line idle: STUCK level samples of 0 after the timeout, then every period.
        step(3);
        check("reset_sample", int'(sample), 0);
        check("reset_valid", int'(sample_valid), 0);
        CPU_RESETN = 1'b1;
        r0 = cyc;
        for (int i = 0; i < 3 * TMO && obs_q.size() < 2; i++) step(1);
        check("stuck_count", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            d0 = obs_q[0].cyc - r0;
            $display("stuck: cyc=%0d sample=%0d locked=%0b", obs_q[0].cyc, obs_q[0].val, obs_q[0].lk);
            $display("stuck: cyc=%0d sample=%0d locked=%0b", obs_q[1].cyc, obs_q[1].val, obs_q[1].lk);
            check("stuck_first_time_in_window", int'(d0 >= TMO && d0 <= TMO + LAT), 1);
            check("stuck0_sample", obs_q[0].val, 0);
            check("stuck0_locked", int'(obs_q[0].lk), 0);
            check("stuck0_err", int'(obs_q[0].er), 0);
            check("stuck_spacing", obs_q[1].cyc - obs_q[0].cyc, PER);
            check("stuck1_sample", obs_q[1].val, 0);
        end
        obs_q.delete();

        // Nominal periods, duty steps, an off-frequency period, then randomized periods.
        for (int i = 0; i < 5; i++) begin pers.push_back(PER); duts.push_back(746); end
        pers.push_back(PER);  duts.push_back(100);
        pers.push_back(PER);  duts.push_back(FS);
        pers.push_back(PER);  duts.push_back(1);
        pers.push_back(2060); duts.push_back(500);
        pers.push_back(PER);  duts.push_back(1234);
        for (int i = 0; i < 6; i++) begin
            p = PER - 8 + int'($urandom_range(0, 16));
            pers.push_back(p);
            duts.push_back(int'($urandom_range(1, p - 1)));
        end
        foreach (pers[i]) drive_period(pers[i], duts[i]);

        // Line stuck high after lock: full-scale level samples via STUCK.
        PWM_in = 1'b1;
        model_rise();
        hold_rise = cyc;
        tracking  = 1'b0;
        push_exp(hold_rise + TMO + LAT, FS, 1'b0, last_err, 1'b1);
        push_exp(hold_rise + TMO + LAT + PER, FS, 1'b0, last_err, 1'b1);
        step(TMO + PER + 8);
        compare_all("track");

        // Restore the PWM: first edge re-enters TRACK silently.
        PWM_in = 1'b0;
        step(100);
        for (int i = 0; i < 3; i++) drive_period(PER, 300 + 200 * i);
        drive_period(40, 10);
        compare_all("restore");

        // Mid-period asynchronous reset.
        PWM_in = 1'b1;
        model_rise();
        last_hi = 300;
        step(300);
        PWM_in = 1'b0;
        step(500);
        compare_all("pre_reset");
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check("async_rst_sample", int'(sample), 0);
        check("async_rst_valid", int'(sample_valid), 0);
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_err", int'(period_err), 0);
        #9;
        CPU_RESETN = 1'b1;
        tracking = 1'b0;
        last_err = 1'b0;
        @(posedge CLK100MHZ);
        #1;
        for (int i = 0; i < 3; i++) drive_period(PER, 746);
        drive_period(40, 10);
        compare_all("post_reset");

        check("no_back_to_back_valid", doubles, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
